div_seq_ctrl: RTL and testbench

- Sequencing controller for the unsigned restoring divider datapath.
- Accepts a start request and checks the divisor for zero.
- Pulses the divisor-register write (w_ctrl_reg1) and the remainder/quotient load.
- Steps the datapath through WIDTH shift/trial-subtract iterations, then signals completion.
- Sits between the top-level divider wrapper and the Divisor/remainder registers and the ALU.

---
 rtl/div_seq_if.sv | 31 +++
 rtl/div_seq_ctrl.sv | 81 ++++++++
 tb/tb_div_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake and datapath-control bundle between the divider wrapper,
// the sequencing controller and the remainder/divisor datapath.
interface div_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] divisor;
    logic             sub_neg;
    logic             w_ctrl_reg1;
    logic             load_rem;
    logic             step_rem;
    logic             q_bit;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Wrapper / datapath side: issues requests, reports the trial-subtract sign.
    modport master (
        output start, abort, divisor, sub_neg,
        input  w_ctrl_reg1, load_rem, step_rem, q_bit, iter_cnt, busy, done, div_zero
    );

    // Controller side.
    modport slave (
        input  start, abort, divisor, sub_neg,
        output w_ctrl_reg1, load_rem, step_rem, q_bit, iter_cnt, busy, done, div_zero
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for an unsigned restoring divider.
// IDLE -> LOAD (1 cycle) -> ITER (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
// A zero divisor skips straight from IDLE to DONE with div_zero set.
// CNT_W must be wide enough to hold the value WIDTH (2**CNT_W > WIDTH).
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic      clk,
    input logic      rst,
    div_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter_cnt;
    logic             div_zero;
    logic             last_iter;
    logic             is_zero;

    assign last_iter = (iter_cnt == CNT_W'(WIDTH - 1));
    assign is_zero   = (bus.divisor == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Iteration counter and divide-by-zero flag. The counter records the work
    // done in the current cycle, so an abort during ITER still counts that
    // cycle's step and then freezes the counter in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (bus.start) div_zero <= is_zero;
                LOAD:    iter_cnt <= '0;
                ITER:    iter_cnt <= iter_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state logic; abort only acts while the datapath is busy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = is_zero ? DONE : LOAD;
            LOAD: state_nxt = bus.abort ? IDLE : ITER;
            ITER: begin
                if (bus.abort)      state_nxt = IDLE;
                else if (last_iter) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode; q_bit is the only output that looks at an input.
    always_comb begin
        bus.w_ctrl_reg1 = (state == LOAD);
        bus.load_rem    = (state == LOAD);
        bus.step_rem    = (state == ITER);
        bus.busy        = (state == LOAD) || (state == ITER);
        bus.done        = (state == DONE);
        bus.q_bit       = (state == ITER) & ~bus.sub_neg;
        bus.iter_cnt    = iter_cnt;
        bus.div_zero    = div_zero;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl. A small restoring-divider datapath
// model supplies sub_neg; results are checked against plain arithmetic
// (dividend / divisor) and against the expected cycle timeline.
module tb_div_seq_ctrl;
    localparam int W  = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    div_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Datapath model: remainder/quotient pair driven by the DUT strobes.
    logic [W-1:0] dividend;
    logic [W-1:0] m_rem, m_quo;
    logic [W:0]   m_shift;
    logic         model_neg;
    logic         force_en  = 1'b0;
    logic         force_val = 1'b0;

    assign m_shift     = {m_rem, m_quo[W-1]};
    assign model_neg   = (m_shift < {1'b0, bus.divisor});
    assign bus.sub_neg = force_en ? force_val : model_neg;

    always @(posedge clk) begin
        if (bus.load_rem) begin
            m_rem <= '0;
            m_quo <= dividend;
        end else if (bus.step_rem) begin
            m_rem <= bus.q_bit ? W'(m_shift - {1'b0, bus.divisor}) : m_shift[W-1:0];
            m_quo <= {m_quo[W-2:0], bus.q_bit};
        end
    end

    task automatic test_reset();
        logic [7:0] got;
        #3;
        got = {bus.w_ctrl_reg1, bus.load_rem, bus.step_rem, bus.q_bit,
               bus.busy, bus.done, bus.div_zero, |bus.iter_cnt};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000", got);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    // Full division; start driven in cycle 0, observed in cycles 1..W+3.
    task automatic test_normal(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        logic [4:0]   got, exp;
        logic [W-1:0] qacc;
        dividend    = dvd;
        bus.divisor = dvs;
        qacc        = '0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp = {n == 1, n == 1, (n >= 2) && (n <= W + 1), (n >= 1) && (n <= W + 1), n == W + 2};
            got = {bus.w_ctrl_reg1, bus.load_rem, bus.step_rem, bus.busy, bus.done};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL normal_timeline cycle %0d: got %b expected %b", n, got, exp);
            end
            if (bus.step_rem) qacc = {qacc[W-2:0], bus.q_bit};
        end
        n_tests++;
        if (qacc !== dvd / dvs) begin
            n_fail++;
            $display("FAIL normal_quotient %0d/%0d: got %0d expected %0d", dvd, dvs, qacc, dvd / dvs);
        end
        n_tests++;
        if (bus.div_zero !== 1'b0 || bus.iter_cnt !== CW'(W)) begin
            n_fail++;
            $display("FAIL normal_final: div_zero=%b iter_cnt=%0d expected 0 %0d",
                     bus.div_zero, bus.iter_cnt, W);
        end
    endtask

    task automatic test_divzero(input logic [W-1:0] dvd);
        logic [4:0] got, exp;
        dividend    = dvd;
        bus.divisor = '0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp = {4'b0000, n == 1};
            got = {bus.w_ctrl_reg1, bus.load_rem, bus.step_rem, bus.busy, bus.done};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL divzero_timeline cycle %0d: got %b expected %b", n, got, exp);
            end
            if (n == 1 || n == 5) begin
                n_tests++;
                if (bus.div_zero !== 1'b1) begin
                    n_fail++;
                    $display("FAIL divzero_flag cycle %0d: got %b expected 1", n, bus.div_zero);
                end
            end
        end
    endtask

    // start held high cycles 0..40: one op, IDLE in 35, second LOAD in 36.
    task automatic test_back_to_back();
        logic [1:0] got, exp;
        dividend    = $urandom;
        bus.divisor = 32'd13;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp = {(n == 1) || (n == 36), n == 34};
            got = {bus.load_rem, bus.done};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL busy_start cycle %0d: load/done got %b expected %b", n, got, exp);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cleanup_abort: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    // Abort while iter_cnt reads 10, then start+abort together from IDLE.
    task automatic test_abort();
        dividend    = $urandom;
        bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_tests++;
        if (bus.step_rem !== 1'b1 || bus.iter_cnt !== CW'(10)) begin
            n_fail++;
            $display("FAIL abort_pre: step=%b iter_cnt=%0d expected 1 10", bus.step_rem, bus.iter_cnt);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_rem !== 1'b0 || bus.iter_cnt !== CW'(11)) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b done=%b step=%b iter_cnt=%0d expected 0 0 0 11",
                     bus.busy, bus.done, bus.step_rem, bus.iter_cnt);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_tests++;
        if (bus.w_ctrl_reg1 !== 1'b1 || bus.load_rem !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: w=%b load=%b busy=%b expected 1 1 1",
                     bus.w_ctrl_reg1, bus.load_rem, bus.busy);
        end
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            n_tests++;
            if (bus.done !== (n == W + 1)) begin
                n_fail++;
                $display("FAIL abort_restart_done cycle +%0d: got %b expected %b", n, bus.done, n == W + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got;
        dividend    = $urandom;
        bus.divisor = 32'd9;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 6 + int'($urandom_range(0, 10)); n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_tests++;
        if (bus.step_rem !== 1'b1 || bus.iter_cnt == '0) begin
            n_fail++;
            $display("FAIL areset_pre: step=%b iter_cnt=%0d expected ITER with nonzero count",
                     bus.step_rem, bus.iter_cnt);
        end
        #2 rst = 1'b0;
        #1;
        got = {bus.w_ctrl_reg1, bus.load_rem, bus.step_rem, bus.q_bit,
               bus.busy, bus.done, bus.div_zero, |bus.iter_cnt};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_immediate: got %b expected 00000000", got);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus.w_ctrl_reg1, bus.load_rem, bus.step_rem, bus.q_bit,
               bus.busy, bus.done, bus.div_zero, |bus.iter_cnt};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_waits_idle: got %b expected 00000000", got);
        end
    endtask

    // sub_neg forced constant: q_bit must follow only the ITER window.
    task automatic test_qbit_gate(input logic neg);
        force_en    = 1'b1;
        force_val   = neg;
        dividend    = $urandom;
        bus.divisor = 32'd3;
        @(negedge clk);
        n_tests++;
        if (bus.q_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL qbit_idle: got %b expected 0", bus.q_bit);
        end
        bus.start = 1'b1;
        for (int n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            n_tests++;
            if (bus.q_bit !== (!neg && n >= 2 && n <= W + 1)) begin
                n_fail++;
                $display("FAIL qbit_gate neg=%b cycle %0d: got %b expected %b",
                         neg, n, bus.q_bit, !neg && n >= 2 && n <= W + 1);
            end
        end
        force_en = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.divisor = '0;
        dividend    = '0;
        test_reset();
        test_normal(32'd100, 32'd7);
        test_divzero(32'd55);
        test_normal(32'hFFFF_FFFF, 32'd1);
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_normal($urandom, 32'd1000);
        test_qbit_gate(1'b0);
        test_qbit_gate(1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] dvs;
            dvs = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            if (dvs == '0) test_divzero($urandom);
            else           test_normal($urandom, dvs);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
